// File: rtl/sumador_pkg.sv
// sumador shared types and constants.
// Optional signed saturation: define SUMADOR_SAT_EN.
package sumador_pkg;

  localparam int SUMADOR_DEFAULT_BITS = 16;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } sumador_flags_t;

  // Signed limit for width w as a raw bit pattern.
  // neg=1 gives -2^(w-1), neg=0 gives 2^(w-1)-1.
  function automatic logic [63:0] sumador_sat_lim(
    input int unsigned w,
    input logic        neg
  );
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/sumador_if.sv
// sumador operand/result bundle.
// Master drives operands, slave returns the registered sum.
interface sumador_if #(
  parameter int bits = 16
);

  logic            in_valid;
  logic [bits-1:0] A;
  logic [bits-1:0] B;
  logic [bits-1:0] R;
  logic            carry;
  logic            overflow;
  logic            zero;
  logic            out_valid;

  modport master (
    output in_valid, A, B,
    input  R, carry, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output R, carry, overflow, zero, out_valid
  );

endinterface

// File: rtl/sumador_core.sv
// sumador combinational sum and flags.
// Saturation compiled only with SUMADOR_SAT_EN.
import sumador_pkg::*;

module sumador_core #(
  parameter int bits = SUMADOR_DEFAULT_BITS
) (
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  output logic [bits-1:0] r,
  output sumador_flags_t  flags
);

  logic [bits:0]   full;
  logic [bits-1:0] sum;
  logic            ovf;
`ifdef SUMADOR_SAT_EN
  logic [63:0]     lim;
`endif

  // Raw sum, carry-out and signed overflow.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sum  = full[bits-1:0];
    ovf  = (a[bits-1] == b[bits-1])
        && (sum[bits-1] != a[bits-1]);
  end

`ifdef SUMADOR_SAT_EN
  // Clamp to the signed limit in the operands' direction.
  always_comb begin
    lim = sumador_sat_lim(bits, a[bits-1]);
    r   = ovf ? lim[bits-1:0] : sum;
  end
`else
  // Plain wrap-around result.
  always_comb begin
    r = sum;
  end
`endif

  // Flags; zero follows the final result.
  always_comb begin
    flags.carry    = full[bits];
    flags.overflow = ovf;
    flags.zero     = (r == '0);
  end

endmodule

// File: rtl/sumador_sync.sv
// sumador_sync: registered adder with status flags.
// Optional signed saturation: define SUMADOR_SAT_EN.
import sumador_pkg::*;

module sumador_sync #(
  parameter int bits = SUMADOR_DEFAULT_BITS
) (
  input  logic      clk,
  input  logic      reset,
  sumador_if.slave  bus
);

  logic [bits-1:0] r_nxt;
  sumador_flags_t  f_nxt;
  logic [bits-1:0] r_q;
  sumador_flags_t  f_q;
  logic            v_q;

  sumador_core #(
    .bits (bits)
  ) u_core (
    .a     (bus.A),
    .b     (bus.B),
    .r     (r_nxt),
    .flags (f_nxt)
  );

  // Output stage: load on valid, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      f_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= bus.in_valid;
      if (bus.in_valid) begin
        r_q <= r_nxt;
        f_q <= f_nxt;
      end
    end
  end

  assign bus.R         = r_q;
  assign bus.carry     = f_q.carry;
  assign bus.overflow  = f_q.overflow;
  assign bus.zero      = f_q.zero;
  assign bus.out_valid = v_q;

endmodule

// File: tb/tb_sumador_sync.sv
// tb_sumador_sync: directed and random checks.
// Expectations follow SUMADOR_SAT_EN when defined.
`timescale 1ns/1ps
module tb_sumador_sync;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  logic [15:0] exp_r;
  logic        exp_c;
  logic        exp_o;
  logic        exp_z;

  sumador_if #(.bits(16)) bus ();

  sumador_sync #(
    .bits (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference model for 16-bit operands.
  task automatic model(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] f;
    logic [15:0] s;
    f = {1'b0, a} + {1'b0, b};
    s = f[15:0];
    exp_c = f[16];
    exp_o = (a[15] == b[15]) && (s[15] != a[15]);
`ifdef SUMADOR_SAT_EN
    if (exp_o)
      s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    exp_r = s;
    exp_z = (s == 16'h0000);
  endtask

  task automatic apply(
    input logic        v,
    input logic [15:0] a,
    input logic [15:0] b
  );
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(
    input string tag,
    input logic  ov
  );
    check({tag, ".R"}, 64'(bus.R), 64'(exp_r));
    check({tag, ".c"}, 64'(bus.carry), 64'(exp_c));
    check({tag, ".o"}, 64'(bus.overflow), 64'(exp_o));
    check({tag, ".z"}, 64'(bus.zero), 64'(exp_z));
    check({tag, ".v"}, 64'(bus.out_valid), 64'(ov));
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;

    apply(1'b1, 16'h1234, 16'h1111);
    apply(1'b1, 16'h1234, 16'h1111);
    exp_r = 16'h0; exp_c = 0; exp_o = 0; exp_z = 0;
    check_all("rst", 1'b0);

    reset = 1'b0;
    apply(1'b1, 16'h0000, 16'h0000);
    exp_r = 16'h0; exp_c = 0; exp_o = 0; exp_z = 1;
    check_all("zero", 1'b1);

    apply(1'b1, 16'hFFFF, 16'h0001);
    exp_r = 16'h0; exp_c = 1; exp_o = 0; exp_z = 1;
    check_all("ffff1", 1'b1);

    apply(1'b1, 16'h7FFF, 16'h0001);
`ifdef SUMADOR_SAT_EN
    exp_r = 16'h7FFF;
`else
    exp_r = 16'h8000;
`endif
    exp_c = 0; exp_o = 1; exp_z = 0;
    check_all("posov", 1'b1);

    apply(1'b1, 16'h8000, 16'h8000);
`ifdef SUMADOR_SAT_EN
    exp_r = 16'h8000; exp_z = 0;
`else
    exp_r = 16'h0000; exp_z = 1;
`endif
    exp_c = 1; exp_o = 1;
    check_all("negov", 1'b1);

    apply(1'b1, 16'h1234, 16'h4321);
    exp_r = 16'h5555; exp_c = 0; exp_o = 0; exp_z = 0;
    check_all("plain", 1'b1);

    for (int i = 0; i < 51; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      apply(1'b1, a, b);
      model(a, b);
      check($sformatf("rnd%0d.R", i),
            64'(bus.R), 64'(exp_r));
      check($sformatf("rnd%0d.f", i),
            64'({bus.carry, bus.overflow, bus.zero}),
            64'({exp_c, exp_o, exp_z}));
      check($sformatf("rnd%0d.v", i),
            64'(bus.out_valid), 64'(1'b1));
    end

    apply(1'b0, 16'h0F0F, 16'h0101);
    check_all("hold", 1'b0);
    apply(1'b0, 16'hAAAA, 16'h5555);
    check_all("hold2", 1'b0);

    apply(1'b1, 16'h0003, 16'h0004);
    exp_r = 16'h0007; exp_c = 0; exp_o = 0; exp_z = 0;
    check_all("pre", 1'b1);

    reset = 1'b1;
    apply(1'b1, 16'h0010, 16'h0020);
    exp_r = 16'h0; exp_c = 0; exp_o = 0; exp_z = 0;
    check_all("midrst", 1'b0);

    reset = 1'b0;
    apply(1'b1, 16'hFFF0, 16'h0020);
    exp_r = 16'h0010; exp_c = 1; exp_o = 0; exp_z = 0;
    check_all("resume", 1'b1);

    apply(1'b0, 16'h0000, 16'h0000);
    check_all("end", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
